// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO between a buart byte source and a 32-bit CPU bus,
//               with STATUS/CTRL registers and a threshold interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    output logic        uart_rd,
    input  logic        select,
    input  logic        rd,
    input  logic [3:0]  we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMPW = (CW > 5) ? CW : 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_ack;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_overrun;
    logic            r_ie;
    logic [4:0]      r_thresh;
    logic [31:0]     r_rdata;
    logic            r_irq;

    logic            w_full;
    logic            w_empty;
    logic            w_bus_rd;
    logic            w_ctrl_wr;
    logic            w_flush;
    logic            w_push;
    logic            w_pop;
    logic            w_ovr_set;
    logic            w_ovr_clr;
    logic [CMPW-1:0] w_count_ext;
    logic [CMPW-1:0] w_thresh_ext;
    logic [4:0]      w_thr_eff;
    logic [4:0]      w_cnt_field;
    logic [31:0]     w_rdata_nxt;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Ingest handshake with the buart
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: if (uart_valid) w_state_nxt = S_ACK;
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (!uart_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign uart_rd = w_ack;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_bus_rd  = select & rd;
    assign w_ctrl_wr = select & we[0] & (addr == 2'd2);
    assign w_flush   = w_ctrl_wr & wdata[5];
    // A flush swallows a coincident push entirely, including its overrun.
    assign w_push    = w_ack & ~w_full & ~w_flush;
    assign w_ovr_set = w_ack & w_full & ~w_flush;
    assign w_ovr_clr = w_ctrl_wr & wdata[6];
    assign w_pop     = w_bus_rd & (addr == 2'd0) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= uart_data;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_overrun <= 1'b0;
            r_ie      <= 1'b0;
            r_thresh  <= 5'd1;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_thresh <= wdata[4:0];
                r_ie     <= wdata[7];
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU read path and interrupt
    // ------------------------------------------------------------------
    assign w_count_ext  = CMPW'(r_count);
    assign w_thr_eff    = (r_thresh == 5'd0) ? 5'd1 : r_thresh;
    assign w_thresh_ext = CMPW'(w_thr_eff);
    assign w_cnt_field  = (w_count_ext > CMPW'(31)) ? 5'd31 : w_count_ext[4:0];

    always_comb begin
        w_rdata_nxt = '0;
        case (addr)
            2'd0:    w_rdata_nxt = {23'b0, ~w_empty, (w_empty ? 8'h00 : r_mem[r_rptr])};
            2'd1:    w_rdata_nxt = {24'b0, r_overrun, w_full, w_empty, w_cnt_field};
            2'd2:    w_rdata_nxt = {24'b0, r_ie, 2'b00, r_thresh};
            default: w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_bus_rd) r_rdata <= w_rdata_nxt;
            r_irq <= r_ie & (r_overrun | (w_count_ext >= w_thresh_ext));
        end
    end

    assign rdata     = r_rdata;
    assign interrupt = r_irq;
    assign w_unused  = ^{we[3:1], wdata[31:8]};

endmodule
`default_nettype wire
